sram_mem_ctrl: RTL
==================

# sram_mem_ctrl

Sequential access controller between the pipeline's MEM stage and the asynchronous, level-sensitive SRAM. Accepts one load/store at a time over a valid/ready handshake and drives the SRAM's address, write data and active-low write enable from registers. Writes use a setup/pulse/hold sequence so the address never moves while write enable is low. Returns read data, or a write acknowledge, as a one-cycle response pulse.

## Interface
- ADDR_WIDTH, 16, request/SRAM address width
- DATA_WIDTH, 16, data width
- RD_WAIT, 2, SRAM access cycles before read data is sampled (legal 1..255)
- WR_PULSE, 2, cycles sram_we_n is held low per write (legal 1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; combinational, = (state==IDLE) & !rst
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  access address
- req_wdata  in  DATA_WIDTH  store data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_is_write  out  1  completed access was a store
- rsp_rdata  out  DATA_WIDTH  load data; valid with rsp_valid for loads
- sram_we_n  out  1  SRAM write enable, active low, registered
- sram_addr  out  ADDR_WIDTH  SRAM address, registered
- sram_data_in  out  DATA_WIDTH  SRAM write data, registered
- sram_data_out  in  DATA_WIDTH  SRAM read data (combinational from sram_addr)

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD. 8-bit down-counter cnt.
- Reset: state IDLE, sram_we_n=1, sram_addr=0, sram_data_in=0, rsp_valid=0, rsp_is_write=0, rsp_rdata=0, cnt=0.
- IDLE: accept when req_valid & req_ready. On accept, register req_addr→sram_addr, req_wdata→sram_data_in (store only), rsp_is_write←req_we. Load → RD with cnt=RD_WAIT-1. Store → WR_SETUP.
- RD: sram_we_n=1. If cnt==0: rsp_rdata←sram_data_out, rsp_valid←1, → IDLE. Else cnt−1.
- WR_SETUP: one cycle, sram_we_n=1, address/data stable. → WR_PULSE, sram_we_n←0, cnt=WR_PULSE-1.
- WR_PULSE: sram_we_n=0. If cnt==0: sram_we_n←1, → WR_HOLD. Else cnt−1.
- WR_HOLD: one cycle, sram_we_n=1, address/data unchanged. rsp_valid←1, → IDLE.
- rsp_valid is high for exactly one cycle per accepted request. rsp_rdata changes only on load completion; a store leaves it unchanged.
- sram_addr and sram_data_in change only at the accepting edge, never while sram_we_n=0. In IDLE they hold the last values.
- sram_we_n is driven only from a flop, never from combinational logic, so it is glitch-free.

## Timing
- Accept edge = E0. Load: rsp_valid high after edge E(RD_WAIT). Store: sram_we_n low from E1 to E(1+WR_PULSE). rsp_valid high after E(2+WR_PULSE).
- Back-to-back: the controller is in IDLE during the rsp_valid cycle, so req_ready=1 and a new request may be accepted in that same cycle.
- Throughput: one load per RD_WAIT cycles; one store per WR_PULSE+2 cycles.
- req_valid while not ready: ignored. The requester must hold the request until accepted.
- Reset mid-operation: the next edge forces all reset values (sram_we_n=1) and no response is issued. An interrupted store leaves the contents at that address undefined.
- A req_valid concurrent with rst is not accepted.

## Test plan
RD_WAIT=2, WR_PULSE=2, SRAM model attached.
- Reset: hold rst 2 cycles -> sram_we_n=1, sram_addr=0, rsp_valid=0, req_ready=0 during reset and 1 after.
- Store addr 0x0010, data 0xBEEF, accepted at E0 -> sram_we_n low exactly during E1–E3; addr=0x0010 stable from E0 to the ack; rsp_valid and rsp_is_write high for one cycle after E4; mem[0x0010]=0xBEEF.
- Load 0x0010 -> rsp_valid after E2, rsp_rdata=0xBEEF, rsp_is_write=0; sram_we_n stays 1 throughout.
- Back-to-back: store 0x0020/0x1234 with req_valid held, then load 0x0020 presented in the ack cycle -> second request accepted in that cycle; load returns 0x1234; no idle cycle between the two.
- Reset asserted in the first WR_PULSE cycle of a store to 0x0030 -> sram_we_n=1 after the next edge; no rsp_valid; controller accepts a new request immediately after rst drops.
- Stall: req_valid held for 3 cycles during an in-flight load -> exactly one accept, and only once back in IDLE; rsp_valid counts equal accept counts over 100 random requests.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
// Single-outstanding load/store controller for an asynchronous, level-sensitive SRAM.
// Writes use setup/pulse/hold phases so the address never moves while sram_we_n is low.
module sram_mem_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_WAIT    = 2,
    parameter int unsigned WR_PULSE   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_is_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_we_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_data_in,
    input  logic [DATA_WIDTH-1:0] sram_data_out
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_n_q, we_n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_is_write_q, rsp_is_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    // Ready is combinational so a new request can be taken in the response cycle.
    assign req_ready = (state_q == ST_IDLE) & ~rst;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        we_n_d         = 1'b1;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rsp_valid_d    = 1'b0;
        rsp_is_write_d = rsp_is_write_q;
        rsp_rdata_d    = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d         = req_addr;
                    rsp_is_write_d = req_we;
                    if (req_we) begin
                        wdata_d = req_wdata;
                        state_d = ST_WR_SETUP;
                    end else begin
                        cnt_d   = RD_INIT;
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == '0) begin
                    rsp_rdata_d = sram_data_out;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                we_n_d  = 1'b0;
                cnt_d   = WR_INIT;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    we_n_d = 1'b0;
                    cnt_d  = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                rsp_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            we_n_q         <= 1'b1;
            addr_q         <= '0;
            wdata_q        <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_is_write_q <= 1'b0;
            rsp_rdata_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            we_n_q         <= we_n_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_is_write_q <= rsp_is_write_d;
            rsp_rdata_q    <= rsp_rdata_d;
        end
    end

    assign sram_we_n    = we_n_q;
    assign sram_addr    = addr_q;
    assign sram_data_in = wdata_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_is_write = rsp_is_write_q;
    assign rsp_rdata    = rsp_rdata_q;

endmodule
